// File: rtl/sysu_rom_player.sv
// Parameterised ROM with a one-cycle random-read port and a streaming playback engine
// (start address, length, optional loop) behind a VALID/READY handshake.
module sysu_rom_player #(
  parameter int unsigned           DW   = 8,
  parameter int unsigned           AW   = 3,
  parameter logic [DW*(2**AW)-1:0] INIT = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] A,
  input  logic          RD,
  input  logic          START,
  input  logic [AW-1:0] SADDR,
  input  logic [AW-1:0] LEN,
  input  logic          LOOP,
  input  logic          STOP,
  input  logic          READY,
  output logic [DW-1:0] Dout,
  output logic          VALID,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {StIdle, StRval, StPlay} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          loop_q, loop_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] ptr_inc;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] addr);
    return INIT[int'(addr)*int'(DW) +: DW];
  endfunction

  // Pointer wraps naturally at DEPTH because it is exactly AW bits wide.
  assign ptr_inc = ptr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    saddr_d = saddr_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          ptr_d   = SADDR;
          cnt_d   = LEN;
          loop_d  = LOOP;
          saddr_d = SADDR;
          len_d   = LEN;
          dout_d  = rom_word(SADDR);
          valid_d = 1'b1;
          state_d = StPlay;
        end else if (RD) begin
          dout_d  = rom_word(A);
          valid_d = 1'b1;
          state_d = StRval;
        end
      end
      StRval: begin
        if (STOP || READY) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      StPlay: begin
        if (STOP) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (valid_q && READY) begin
          if (cnt_q != '0) begin
            ptr_d  = ptr_inc;
            cnt_d  = cnt_q - AW'(1);
            dout_d = rom_word(ptr_inc);
          end else if (loop_q) begin
            ptr_d  = saddr_q;
            cnt_d  = len_q;
            dout_d = rom_word(saddr_q);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      saddr_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      saddr_q <= saddr_d;
      len_q   <= len_d;
    end
  end

  assign Dout  = dout_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q != StIdle);
  assign DONE  = done_q;

endmodule

// File: tb/tb_sysu_rom_player.sv
// Bench for sysu_rom_player: directed vector table, async-reset sequence, and random
// stimulus compared against a sequence-position reference model.
module tb_sysu_rom_player;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam logic [63:0] INIT = 64'h17161514_13121110;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [AW-1:0] A, SADDR, LEN;
  logic          RD, START, LOOP, STOP, READY;
  logic [DW-1:0] Dout;
  logic          VALID, BUSY, DONE;

  int n_checks = 0;
  int n_fail   = 0;

  sysu_rom_player #(.DW(DW), .AW(AW), .INIT(INIT)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .RD(RD), .START(START), .SADDR(SADDR), .LEN(LEN),
    .LOOP(LOOP), .STOP(STOP), .READY(READY), .Dout(Dout), .VALID(VALID), .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rd;
    logic [2:0] a;
    logic       start;
    logic [2:0] saddr;
    logic [2:0] len;
    logic       loop;
    logic       stop;
    logic       ready;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rd, logic [2:0] a, logic start, logic [2:0] saddr,
                              logic [2:0] len, logic loop, logic stop, logic ready,
                              logic [7:0] dout, logic valid, logic busy, logic done);
    vec_t v;
    v.rd = rd; v.a = a; v.start = start; v.saddr = saddr; v.len = len; v.loop = loop;
    v.stop = stop; v.ready = ready; v.dout = dout; v.valid = valid; v.busy = busy;
    v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic [2:0] a, input logic start,
                       input logic [2:0] saddr, input logic [2:0] len, input logic loop,
                       input logic stop, input logic ready);
    RD = rd; A = a; START = start; SADDR = saddr; LEN = len; LOOP = loop; STOP = stop;
    READY = ready;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: tracks position within the requested word sequence.
  int         m_mode;  // 0 idle, 1 single read, 2 playback
  logic [7:0] m_dout;
  logic       m_valid, m_done;
  int         m_start_addr, m_len, m_pos;
  logic       m_loop;

  function automatic logic [7:0] word_at(int addr);
    return 8'(8'h10 + (addr % 8));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_dout = 8'h00; m_valid = 1'b0; m_done = 1'b0;
    m_start_addr = 0; m_len = 0; m_pos = 0; m_loop = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    case (m_mode)
      0: begin
        if (START) begin
          m_start_addr = int'(SADDR); m_len = int'(LEN); m_loop = LOOP; m_pos = 0;
          m_dout = word_at(m_start_addr); m_valid = 1'b1; m_mode = 2;
        end else if (RD) begin
          m_dout = word_at(int'(A)); m_valid = 1'b1; m_mode = 1;
        end
      end
      1: begin
        if (STOP || READY) begin
          m_valid = 1'b0; m_mode = 0;
        end
      end
      default: begin
        if (STOP) begin
          m_valid = 1'b0; m_mode = 0;
        end else if (READY) begin
          if (m_pos < m_len) begin
            m_pos++;
            m_dout = word_at(m_start_addr + m_pos);
          end else if (m_loop) begin
            m_pos = 0;
            m_dout = word_at(m_start_addr);
          end else begin
            m_valid = 1'b0; m_done = 1'b1; m_mode = 0;
          end
        end
      end
    endcase
  endtask

  initial begin
    RST_N = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_dout", 32'(Dout), 32'h00);
    chk("reset_valid", 32'(VALID), 32'h0);
    chk("reset_busy", 32'(BUSY), 32'h0);
    chk("reset_done", 32'(DONE), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    //          rd a  st sa ln lp sp rdy  dout   v  b  d
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 8'h15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h15, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6, 3, 0, 0, 1, 8'h16, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h17, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h11, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h11, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6, 3, 0, 0, 1, 8'h16, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h16, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h17, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h17, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h11, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h11, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 2, 1, 1, 0, 1, 8'h12, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h13, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h12, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h13, 1, 1, 0));
    tbl.push_back(mk(1, 7, 1, 0, 5, 0, 0, 1, 8'h12, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h12, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 8'h11, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 0, 0, 8'h11, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h11, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 7, 0, 0, 0, 0, 8'h17, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h17, 0, 0, 1));

    @(posedge CLK);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].a, tbl[i].start, tbl[i].saddr, tbl[i].len, tbl[i].loop,
            tbl[i].stop, tbl[i].ready);
      tick();
      chk($sformatf("vec%0d_dout", i), 32'(Dout), 32'(tbl[i].dout));
      chk($sformatf("vec%0d_valid", i), 32'(VALID), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(DONE), 32'(tbl[i].done));
    end

    // Asynchronous reset between edges in the middle of a playback.
    drive(0, 0, 1, 0, 7, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    chk("midplay_dout", 32'(Dout), 32'h12);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_rst_dout", 32'(Dout), 32'h00);
    chk("async_rst_valid", 32'(VALID), 32'h0);
    chk("async_rst_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d_done", i), 32'(DONE), 32'h0);
      chk($sformatf("post_rst%0d_valid", i), 32'(VALID), 32'h0);
    end
    drive(0, 0, 1, 3, 0, 0, 0, 0);
    tick();
    chk("post_rst_start_dout", 32'(Dout), 32'h13);
    chk("post_rst_start_valid", 32'(VALID), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("post_rst_start_done", 32'(DONE), 32'h1);

    // Random stimulus against the reference model.
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) == 0), 3'($urandom), ($urandom_range(0, 4) == 0),
            3'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) != 0));
      @(posedge CLK);
      model_step();
      #1;
      chk($sformatf("rnd%0d", i), {21'd0, (m_mode != 0), m_done, m_valid, m_dout},
          {21'd0, BUSY, DONE, VALID, Dout});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
